// File: rtl/tl_ram_responder_if.sv
// -----------------------------------------------------------------------------
// tl_ram_responder_if
//   TileLink-UL A/D channel bundle between a fragmenting coupler (master) and
//   the RAM responder (slave). Signal names keep the coupler's auto_in_*
//   naming so the bundle maps one-to-one onto the generated interconnect.
//
//   A channel : auto_in_a_valid/ready, opcode(3), size(2), source(9),
//               address(28), mask(8), data(64)
//   D channel : auto_in_d_valid/ready, opcode(3), size(2), source(9), data(64)
// -----------------------------------------------------------------------------
interface tl_ram_responder_if;
  logic        auto_in_a_ready;
  logic        auto_in_a_valid;
  logic [2:0]  auto_in_a_bits_opcode;
  logic [1:0]  auto_in_a_bits_size;
  logic [8:0]  auto_in_a_bits_source;
  logic [27:0] auto_in_a_bits_address;
  logic [7:0]  auto_in_a_bits_mask;
  logic [63:0] auto_in_a_bits_data;

  logic        auto_in_d_ready;
  logic        auto_in_d_valid;
  logic [2:0]  auto_in_d_bits_opcode;
  logic [1:0]  auto_in_d_bits_size;
  logic [8:0]  auto_in_d_bits_source;
  logic [63:0] auto_in_d_bits_data;

  modport master (
    input  auto_in_a_ready,
    output auto_in_a_valid, auto_in_a_bits_opcode, auto_in_a_bits_size,
           auto_in_a_bits_source, auto_in_a_bits_address, auto_in_a_bits_mask,
           auto_in_a_bits_data,
    output auto_in_d_ready,
    input  auto_in_d_valid, auto_in_d_bits_opcode, auto_in_d_bits_size,
           auto_in_d_bits_source, auto_in_d_bits_data
  );

  modport slave (
    output auto_in_a_ready,
    input  auto_in_a_valid, auto_in_a_bits_opcode, auto_in_a_bits_size,
           auto_in_a_bits_source, auto_in_a_bits_address, auto_in_a_bits_mask,
           auto_in_a_bits_data,
    input  auto_in_d_ready,
    output auto_in_d_valid, auto_in_d_bits_opcode, auto_in_d_bits_size,
           auto_in_d_bits_source, auto_in_d_bits_data
  );
endinterface

// File: rtl/tl_ram_responder.sv
// -----------------------------------------------------------------------------
// tl_ram_responder
//   TileLink-UL slave endpoint backed by a word-addressed 64-bit RAM. Every
//   accepted A beat produces exactly one D beat from a single response
//   register that reloads on the same edge it drains, so one request per
//   cycle is sustained while the D side is ready.
//
//   clock     : sole clock, rising edge
//   reset     : synchronous, active-high; clears the response register and
//               the error counter, leaves RAM contents untouched
//   tl        : A/D channel bundle (slave side)
//   err_count : saturating count of rejected requests (out of range or
//               unsupported opcode)
// -----------------------------------------------------------------------------
module tl_ram_responder #(
  parameter logic [27:0] BASE_ADDR     = 28'h0000000,
  parameter int          DEPTH_WORDS   = 512,
  parameter int          ERR_CNT_WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  tl_ram_responder_if.slave        tl,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  // One extra bit so BASE_ADDR + size cannot wrap at the top of the space.
  localparam logic [28:0] LIMIT = {1'b0, BASE_ADDR} + 29'(DEPTH_WORDS * 8);

  typedef enum logic [2:0] {
    OP_PUT_FULL    = 3'd0,
    OP_PUT_PARTIAL = 3'd1,
    OP_GET         = 3'd4
  } a_op_e;

  typedef enum logic [2:0] {
    D_ACCESS_ACK      = 3'd0,
    D_ACCESS_ACK_DATA = 3'd1
  } d_op_e;

  logic [63:0] mem [DEPTH_WORDS];

  logic                     d_valid_q,  d_valid_d;
  logic [2:0]               d_opcode_q, d_opcode_d;
  logic [1:0]               d_size_q,   d_size_d;
  logic [8:0]               d_source_q, d_source_d;
  logic [63:0]              d_data_q,   d_data_d;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q,  err_cnt_d;

  logic             a_fire;
  logic             is_get, is_put, in_range;
  logic             wr_en, rejected;
  logic [IDX_W-1:0] idx;

  // Ready whenever the response register is empty or draining this cycle.
  assign tl.auto_in_a_ready = !reset && (!d_valid_q || tl.auto_in_d_ready);
  assign a_fire             = tl.auto_in_a_valid && tl.auto_in_a_ready;

  assign is_get   = tl.auto_in_a_bits_opcode == OP_GET;
  assign is_put   = tl.auto_in_a_bits_opcode == OP_PUT_FULL ||
                    tl.auto_in_a_bits_opcode == OP_PUT_PARTIAL;
  assign in_range = {1'b0, tl.auto_in_a_bits_address} >= {1'b0, BASE_ADDR} &&
                    {1'b0, tl.auto_in_a_bits_address} <  LIMIT;
  // BASE_ADDR is aligned to the array size, so the low index bits are the
  // word offset from the base.
  assign idx      = tl.auto_in_a_bits_address[3 +: IDX_W];
  assign wr_en    = a_fire && is_put && in_range;
  assign rejected = a_fire && (!in_range || !(is_get || is_put));

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    d_valid_d  = d_valid_q;
    d_opcode_d = d_opcode_q;
    d_size_d   = d_size_q;
    d_source_d = d_source_q;
    d_data_d   = d_data_q;
    err_cnt_d  = err_cnt_q;

    if (a_fire) begin
      d_valid_d  = 1'b1;
      d_opcode_d = is_get ? D_ACCESS_ACK_DATA : D_ACCESS_ACK;
      d_size_d   = tl.auto_in_a_bits_size;
      d_source_d = tl.auto_in_a_bits_source;
      // The read sees the pre-write word; a Get never writes, so there is
      // no same-edge read/write collision.
      d_data_d   = (is_get && in_range) ? mem[idx] : 64'd0;
    end else if (tl.auto_in_d_ready) begin
      d_valid_d = 1'b0;
    end

    if (rejected && err_cnt_q != '1) begin
      err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before the edge, regardless of block order.
  always_ff @(posedge clock) begin
    if (reset) begin
      d_valid_q  <= 1'b0;
      d_opcode_q <= 3'd0;
      d_size_q   <= 2'd0;
      d_source_q <= 9'd0;
      d_data_q   <= 64'd0;
      err_cnt_q  <= '0;
    end else begin
      d_valid_q  <= d_valid_d;
      d_opcode_q <= d_opcode_d;
      d_size_q   <= d_size_d;
      d_source_q <= d_source_d;
      d_data_q   <= d_data_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // NOTE: the array deliberately has no reset so it maps onto plain RAM
  // macros and keeps its contents across a reset.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int i = 0; i < 8; i++) begin
        if (tl.auto_in_a_bits_mask[i]) begin
          mem[idx][8*i +: 8] <= tl.auto_in_a_bits_data[8*i +: 8];
        end
      end
    end
  end

  assign tl.auto_in_d_valid       = d_valid_q;
  assign tl.auto_in_d_bits_opcode = d_opcode_q;
  assign tl.auto_in_d_bits_size   = d_size_q;
  assign tl.auto_in_d_bits_source = d_source_q;
  assign tl.auto_in_d_bits_data   = d_data_q;
  assign err_count                = err_cnt_q;

endmodule

// File: tb/tb_tl_ram_responder.sv
// -----------------------------------------------------------------------------
// tb_tl_ram_responder
//   Directed bench for tl_ram_responder (BASE_ADDR=0, DEPTH_WORDS=512,
//   ERR_CNT_WIDTH=8). Inputs change and outputs are sampled on the falling
//   edge, half a period away from the active rising edge.
// -----------------------------------------------------------------------------
module tb_tl_ram_responder;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] err_count;
  int         total = 0;
  int         bad   = 0;

  tl_ram_responder_if bus ();

  tl_ram_responder #(
    .BASE_ADDR    (28'h0000000),
    .DEPTH_WORDS  (512),
    .ERR_CNT_WIDTH(8)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .tl       (bus.slave),
    .err_count(err_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  task automatic drive_a(input logic [2:0] op, input logic [1:0] size, input logic [8:0] src,
                         input logic [27:0] addr, input logic [7:0] mask, input logic [63:0] data);
    bus.auto_in_a_valid        = 1'b1;
    bus.auto_in_a_bits_opcode  = op;
    bus.auto_in_a_bits_size    = size;
    bus.auto_in_a_bits_source  = src;
    bus.auto_in_a_bits_address = addr;
    bus.auto_in_a_bits_mask    = mask;
    bus.auto_in_a_bits_data    = data;
  endtask

  task automatic idle_a();
    bus.auto_in_a_valid        = 1'b0;
    bus.auto_in_a_bits_opcode  = 3'd0;
    bus.auto_in_a_bits_size    = 2'd0;
    bus.auto_in_a_bits_source  = 9'd0;
    bus.auto_in_a_bits_address = 28'd0;
    bus.auto_in_a_bits_mask    = 8'd0;
    bus.auto_in_a_bits_data    = 64'd0;
  endtask

  task automatic check_d(input string tag, input logic [2:0] op, input logic [1:0] size,
                         input logic [8:0] src, input logic [63:0] data);
    check({tag, ".d_valid"},  64'(bus.auto_in_d_valid),       64'd1);
    check({tag, ".d_opcode"}, 64'(bus.auto_in_d_bits_opcode), 64'(op));
    check({tag, ".d_size"},   64'(bus.auto_in_d_bits_size),   64'(size));
    check({tag, ".d_source"}, 64'(bus.auto_in_d_bits_source), 64'(src));
    check({tag, ".d_data"},   bus.auto_in_d_bits_data,        data);
  endtask

  // One request with d_ready high: accept, check the response, let it drain.
  task automatic transact(input string tag, input logic [2:0] op, input logic [1:0] size,
                          input logic [8:0] src, input logic [27:0] addr, input logic [7:0] mask,
                          input logic [63:0] data, input logic [2:0] exp_op, input logic [63:0] exp_data);
    drive_a(op, size, src, addr, mask, data);
    #1;
    check({tag, ".a_ready"}, 64'(bus.auto_in_a_ready), 64'd1);
    step();
    idle_a();
    check_d(tag, exp_op, size, src, exp_data);
    step();
  endtask

  initial begin
    logic [63:0] exp_data;

    reset               = 1'b1;
    bus.auto_in_d_ready = 1'b1;
    idle_a();
    repeat (3) step();

    // Reset state
    check("rst.a_ready",  64'(bus.auto_in_a_ready),       64'd0);
    check("rst.d_valid",  64'(bus.auto_in_d_valid),       64'd0);
    check("rst.d_opcode", 64'(bus.auto_in_d_bits_opcode), 64'd0);
    check("rst.d_source", 64'(bus.auto_in_d_bits_source), 64'd0);
    check("rst.d_data",   bus.auto_in_d_bits_data,        64'd0);
    check("rst.err",      64'(err_count),                 64'd0);
    reset = 1'b0;
    step();

    // Put then Get
    transact("put_full", 3'd0, 2'd3, 9'h1A5, 28'h40, 8'hFF, 64'h1122334455667788, 3'd0, 64'd0);
    transact("get_full", 3'd4, 2'd3, 9'h012, 28'h40, 8'hFF, 64'd0, 3'd1, 64'h1122334455667788);

    // Partial write over a cleared word
    transact("clr_word", 3'd0, 2'd3, 9'h013, 28'h40, 8'hFF, 64'd0, 3'd0, 64'd0);
    transact("put_part", 3'd1, 2'd2, 9'h014, 28'h40, 8'h0F, 64'hAAAAAAAA_BBBBBBBB, 3'd0, 64'd0);
    transact("get_part", 3'd4, 2'd3, 9'h015, 28'h40, 8'hFF, 64'd0, 3'd1, 64'h00000000_BBBBBBBB);

    // Backpressure: Get held in the response register for 5 cycles
    bus.auto_in_d_ready = 1'b0;
    drive_a(3'd4, 2'd3, 9'h055, 28'h40, 8'hFF, 64'd0);
    step();
    drive_a(3'd0, 2'd3, 9'h033, 28'h48, 8'hFF, 64'hCAFEF00D_12345678);
    #1;
    for (int i = 0; i < 5; i++) begin
      check_d("hold", 3'd1, 2'd3, 9'h055, 64'h00000000_BBBBBBBB);
      check("hold.a_ready", 64'(bus.auto_in_a_ready), 64'd0);
      step();
    end
    bus.auto_in_d_ready = 1'b1;
    #1;
    check("release.a_ready", 64'(bus.auto_in_a_ready), 64'd1);
    step();
    idle_a();
    check_d("release", 3'd0, 2'd3, 9'h033, 64'd0);
    step();
    check("release.drained", 64'(bus.auto_in_d_valid), 64'd0);
    transact("get_bp_put", 3'd4, 2'd3, 9'h034, 28'h48, 8'hFF, 64'd0, 3'd1, 64'hCAFEF00D_12345678);

    // Streaming: 8 back-to-back Gets, responses one per cycle in order
    for (int i = 0; i <= 8; i++) begin
      if (i > 0) begin
        exp_data = ((i - 1) % 2 == 1) ? 64'hCAFEF00D_12345678 : 64'h00000000_BBBBBBBB;
        check_d("stream", 3'd1, 2'd3, 9'(9'h100 + i - 1), exp_data);
      end
      if (i < 8) begin
        drive_a(3'd4, 2'd3, 9'(9'h100 + i), (i % 2 == 1) ? 28'h48 : 28'h40, 8'hFF, 64'd0);
        #1;
        check("stream.a_ready", 64'(bus.auto_in_a_ready), 64'd1);
      end else begin
        idle_a();
      end
      step();
    end
    check("stream.drained", 64'(bus.auto_in_d_valid), 64'd0);

    // Errors
    transact("get_oob", 3'd4, 2'd3, 9'h1F0, 28'h1000, 8'hFF, 64'd0, 3'd1, 64'd0);
    check("get_oob.err", 64'(err_count), 64'd1);
    transact("op2", 3'd2, 2'd3, 9'h1F1, 28'h40, 8'hFF, 64'hDEADBEEF_DEADBEEF, 3'd0, 64'd0);
    check("op2.err", 64'(err_count), 64'd2);
    transact("put_oob", 3'd0, 2'd3, 9'h1F2, 28'h1000, 8'hFF, 64'h5555555555555555, 3'd0, 64'd0);
    check("put_oob.err", 64'(err_count), 64'd3);
    transact("put_nomask", 3'd1, 2'd3, 9'h1F3, 28'h40, 8'h00, 64'hFFFFFFFF_FFFFFFFF, 3'd0, 64'd0);
    check("put_nomask.err", 64'(err_count), 64'd3);
    transact("get_after_err", 3'd4, 2'd3, 9'h1F4, 28'h40, 8'hFF, 64'd0, 3'd1, 64'h00000000_BBBBBBBB);

    // Saturation: 252 streamed bad opcodes bring the count to 255
    drive_a(3'd7, 2'd3, 9'h1F5, 28'h40, 8'hFF, 64'd0);
    repeat (252) step();
    idle_a();
    step();
    check("sat.err", 64'(err_count), 64'd255);
    transact("sat_more", 3'd5, 2'd1, 9'h1F6, 28'h40, 8'hFF, 64'd0, 3'd0, 64'd0);
    check("sat_more.err", 64'(err_count), 64'd255);

    // Reset with a response pending
    bus.auto_in_d_ready = 1'b0;
    drive_a(3'd4, 2'd3, 9'h0AA, 28'h48, 8'hFF, 64'd0);
    step();
    idle_a();
    check("pend.d_valid", 64'(bus.auto_in_d_valid), 64'd1);
    reset = 1'b1;
    step();
    check("midrst.d_valid",  64'(bus.auto_in_d_valid),       64'd0);
    check("midrst.d_source", 64'(bus.auto_in_d_bits_source), 64'd0);
    check("midrst.err",      64'(err_count),                 64'd0);
    check("midrst.a_ready",  64'(bus.auto_in_a_ready),       64'd0);
    reset               = 1'b0;
    bus.auto_in_d_ready = 1'b1;
    step();
    transact("get_after_rst", 3'd4, 2'd3, 9'h0AB, 28'h48, 8'hFF, 64'd0, 3'd1, 64'hCAFEF00D_12345678);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tl_ram_responder.md
Name: tl_ram_responder

Overview:
- TileLink-UL responder (slave endpoint) that terminates the fragmenter output side of an interconnect coupler.
- Accepts single-beat A-channel requests (size ≤ 8 bytes, 9-bit source, 28-bit address, 64-bit data) into a word-addressed RAM.
- Returns one D-channel beat per request.
- Provides scratchpad/test memory behind a fragmenting coupler; also serves as the verification responder for the coupler path.

Parameters:
- BASE_ADDR, 28'h0000000, byte address of the first RAM word; must be aligned to DEPTH_WORDS*8.
- DEPTH_WORDS, 512, number of 64-bit words; power of two, 2..4096.
- ERR_CNT_WIDTH, 8, width of the saturating error counter.

Ports:
- clock  in  1  sole clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- auto_in_a_ready  out  1  A-channel ready
- auto_in_a_valid  in  1  A-channel valid
- auto_in_a_bits_opcode  in  3  0=PutFullData, 1=PutPartialData, 4=Get; others unsupported
- auto_in_a_bits_size  in  2  log2 bytes (0..3)
- auto_in_a_bits_source  in  9  request tag
- auto_in_a_bits_address  in  28  byte address
- auto_in_a_bits_mask  in  8  byte lanes
- auto_in_a_bits_data  in  64  write data
- auto_in_d_ready  in  1  D-channel ready
- auto_in_d_valid  out  1  D-channel valid
- auto_in_d_bits_opcode  out  3  0=AccessAck, 1=AccessAckData
- auto_in_d_bits_size  out  2  echo of request size
- auto_in_d_bits_source  out  9  echo of request source
- auto_in_d_bits_data  out  64  read data; 0 for AccessAck
- err_count  out  ERR_CNT_WIDTH  saturating count of rejected requests

Behaviour:
- Reset (synchronous, active-high):
  - d_valid=0, d_opcode/size/source/data=0, err_count=0.
  - auto_in_a_ready forced 0 while reset is high.
  - RAM contents are not reset.
- Handshake:
  - A fire = a_valid & a_ready; D fire = d_valid & d_ready.
  - a_ready = !reset & (!d_valid | d_ready), i.e. a single response register with pass-through on drain.
  - Sustains one request per cycle when d_ready is held high.
- Latency: a request accepted at edge N has its response registered at edge N (d_valid visible in cycle N+1).
  - A D fire and an A fire in the same cycle: the old response retires and the new one loads at the same edge; d_valid stays 1.
  - A D fire with no A fire clears d_valid.
- Response hold: while d_valid=1 and d_ready=0, all d_* outputs stay stable and a_ready=0.
- Decode:
  - in_range = (address >= BASE_ADDR) & (address < BASE_ADDR + DEPTH_WORDS*8).
  - Word index = address[3 +: log2(DEPTH_WORDS)].
  - Address bits [2:0] and size are not used for indexing; the mask selects bytes.
- Get: d_opcode=1; d_data = RAM[index] as read at the accept edge (pre-write value of that edge; no same-edge write is possible).
- PutFullData / PutPartialData:
  - For each mask bit i set, RAM[index] byte i ← a_data byte i at the accept edge.
  - d_opcode=0, d_data=0.
  - A Get accepted in the next cycle sees the new data.
- Out of range:
  - Get → AccessAckData with data 0.
  - Put → AccessAck with no RAM write.
  - err_count increments.
- Unsupported opcode (2, 3, 5, 6, 7): AccessAck, data 0, no RAM write, err_count increments.
- Empty mask on a Put: AccessAck, no write, not an error.
- err_count: increments by 1 per rejected A fire; saturates at 2^ERR_CNT_WIDTH−1 and does not wrap.
- Reset mid-operation:
  - A pending un-acked response is discarded (d_valid=0 at the next edge).
  - Writes accepted before reset persist.
- d_size and d_source always equal the request's size and source, including error cases.
- The RAM is a single-port synchronous array: one read or one write per cycle, no read-modify-write hazard.

Test Plan:
- Put then Get, BASE=0: PutFullData addr 0x40, mask 0xFF, data 0x1122334455667788, source 0x1A5. → AccessAck with source 0x1A5 in the next cycle. Then Get addr 0x40 size 3. → AccessAckData data 0x1122334455667788.
- Partial write: preload word 0x40 with 0, then PutPartialData mask 0x0F data 0xAAAAAAAA_BBBBBBBB. → Get returns 0x00000000_BBBBBBBB.
- Backpressure: hold d_ready=0 with a Get pending. → d_* outputs stable for 5 cycles and a_ready=0. Release d_ready. → D fire, and a new A is accepted in the same cycle.
- Streaming: 8 back-to-back Gets with d_ready=1. → 8 consecutive D beats, one per cycle, sources in order, no bubbles.
- Errors:
  - Get addr 0x1000 (DEPTH=512) → data 0, err_count=1.
  - opcode 2 → AccessAck, err_count=2.
  - Force err_count to 255 → stays 255 after a further error.
- Reset with d_valid=1 and d_ready=0 → d_valid=0 and err_count=0 after the edge; previously written data is still readable.
